sad_feeder: RTL and testbench

- Initiator for the SAD accelerator (sad).
- Holds two 256-sample 8-bit blocks (A, B) loaded by a host write port.
- On start, streams the sample pairs into sad's dta_i/dtb_i/enb_i interface, waits for sad to go idle, captures dt_o, and hands the 32-bit result to the host over a valid/ready port.

---
 rtl/sad_pkg.sv | 24 ++
 rtl/sad_pair_buf.sv | 30 +++
 rtl/sad_feeder.sv | 130 +++++++++++++
 tb/tb_sad_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD accelerator and its feeder.
// No logic of its own; latency and backpressure belong to the importing modules.
// Nothing here stalls.
package sad_pkg;

    localparam int SAD_N_SAMPLES = 256;
    localparam int SAD_DW        = 8;
    localparam int SAD_RW        = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } sad_feed_state_t;

    // One extra bit so the difference of two full-scale samples never wraps.
    function automatic logic [SAD_DW:0] sad_absdiff(input logic [SAD_DW-1:0] a,
                                                     input logic [SAD_DW-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/sad_pair_buf.sv
// Paired A/B sample store: one write port, one combinational read port returning {A[addr], B[addr]}.
// Write lands on the next rising edge; read is zero-latency.
// No backpressure; the owner gates writes.
module sad_pair_buf #(
    parameter int N_SAMPLES = 256,
    parameter int DW        = 8
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [$clog2(N_SAMPLES)-1:0] wr_addr,
    input  logic [DW-1:0]                wr_data,
    input  logic [$clog2(N_SAMPLES)-1:0] rd_addr,
    output logic [2*DW-1:0]              rd_pair
);

    logic [DW-1:0] buf_a [N_SAMPLES];
    logic [DW-1:0] buf_b [N_SAMPLES];

    // Contents are deliberately not reset; the host reloads them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel) buf_b[wr_addr] <= wr_data;
            else        buf_a[wr_addr] <= wr_data;
        end
    end

    assign rd_pair = {buf_a[rd_addr], buf_b[rd_addr]};

endmodule

// File: rtl/sad_feeder.sv
// Feeds two sample blocks into the SAD engine one pair per cycle and returns its result to the host.
// Start to first pair: 2 cycles; start to result valid: 2 + N_SAMPLES + max(WAIT_MIN, busy fall) + 1.
// Holds off while sad is busy; result is held until res_ready_i. SAD_FEEDER_CHECK_EN adds mismatch_o.
module sad_feeder
    import sad_pkg::*;
#(
    parameter int N_SAMPLES = SAD_N_SAMPLES,
    parameter int DW        = SAD_DW,
    parameter int RW        = SAD_RW,
    parameter int WAIT_MIN  = 4
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic                         wr_sel_i,
    input  logic [$clog2(N_SAMPLES)-1:0] wr_addr_i,
    input  logic [DW-1:0]                wr_data_i,
    input  logic                         start_i,
    output logic                         idle_o,
    output logic                         sad_enb_o,
    output logic [DW-1:0]                sad_dta_o,
    output logic [DW-1:0]                sad_dtb_o,
    input  logic                         sad_busy_i,
    input  logic [RW-1:0]                sad_dt_i,
    output logic                         res_valid_o,
    output logic [RW-1:0]                res_data_o,
    input  logic                         res_ready_i
`ifdef SAD_FEEDER_CHECK_EN
    ,
    output logic                         mismatch_o
`endif
);

    localparam int AW = $clog2(N_SAMPLES);
    localparam int CW = $clog2(WAIT_MIN + 2);

    sad_feed_state_t state;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   rd_addr;
    logic [CW-1:0]   wait_cnt;
    logic [2*DW-1:0] rd_pair;
    logic            stream_go;
    logic            capture;

    assign idle_o    = (state == IDLE);
    assign stream_go = (state == ARM) && !sad_busy_i;
    assign capture   = (state == WAIT) && (wait_cnt == CW'(WAIT_MIN)) && !sad_busy_i;
    // Look one pair ahead so the stream outputs can stay registered.
    assign rd_addr   = (state == STREAM) ? idx + AW'(1) : '0;

    sad_pair_buf #(
        .N_SAMPLES (N_SAMPLES),
        .DW        (DW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_i & idle_o),
        .wr_sel  (wr_sel_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (rd_addr),
        .rd_pair (rd_pair)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            sad_enb_o   <= 1'b0;
            sad_dta_o   <= '0;
            sad_dtb_o   <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) state <= ARM;
                ARM: if (stream_go) begin
                    state                  <= STREAM;
                    idx                    <= '0;
                    sad_enb_o              <= 1'b1;
                    {sad_dta_o, sad_dtb_o} <= rd_pair;
                end
                STREAM: begin
                    if (idx == AW'(N_SAMPLES - 1)) begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        sad_enb_o <= 1'b0;
                        sad_dta_o <= '0;
                        sad_dtb_o <= '0;
                    end else begin
                        idx                    <= idx + AW'(1);
                        {sad_dta_o, sad_dtb_o} <= rd_pair;
                    end
                end
                WAIT: begin
                    if (wait_cnt != CW'(WAIT_MIN)) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end else if (capture) begin
                        res_data_o  <= sad_dt_i;
                        res_valid_o <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: if (res_ready_i) begin
                    res_valid_o <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAD_FEEDER_CHECK_EN
    logic [RW-1:0] acc;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            acc        <= '0;
            mismatch_o <= 1'b0;
        end else if (stream_go) begin
            acc <= '0;
        end else if (state == STREAM) begin
            acc <= acc + RW'(sad_absdiff(sad_dta_o, sad_dtb_o));
        end else if (capture) begin
            mismatch_o <= (acc != sad_dt_i);
        end
    end
`endif

endmodule

// File: tb/tb_sad_feeder.sv
// Directed bench for sad_feeder with a behavioural sad responder on the far side.
module tb_sad_feeder;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_en_i = 1'b0;
    logic        wr_sel_i = 1'b0;
    logic [7:0]  wr_addr_i = '0;
    logic [7:0]  wr_data_i = '0;
    logic        start_i = 1'b0;
    logic        idle_o;
    logic        sad_enb_o;
    logic [7:0]  sad_dta_o;
    logic [7:0]  sad_dtb_o;
    logic        sad_busy_i;
    logic [31:0] sad_dt_i;
    logic        res_valid_o;
    logic [31:0] res_data_o;
    logic        res_ready_i = 1'b0;
`ifdef SAD_FEEDER_CHECK_EN
    logic        mismatch_o;
`endif

    logic        force_busy = 1'b0;
    logic        resp_busy = 1'b0;
    logic [31:0] resp_sum = '0;
    logic [31:0] resp_dt = '0;
    int          tail = 0;
    logic        prev_enb = 1'b0;
    bit          corrupt = 1'b0;

    int checks = 0;
    int failures = 0;
    int cnt;
    int t;

    logic [7:0] mA [N];
    logic [7:0] mB [N];

    typedef struct {
        bit          a_ramp;
        logic [7:0]  a_val;
        logic [7:0]  b_val;
        int          exp;
    } vec_t;
    vec_t vecs [5];

    assign sad_busy_i = force_busy | resp_busy;
    assign sad_dt_i   = resp_dt;

    always #5 clk = ~clk;

    sad_feeder dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_sel_i    (wr_sel_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .start_i     (start_i),
        .idle_o      (idle_o),
        .sad_enb_o   (sad_enb_o),
        .sad_dta_o   (sad_dta_o),
        .sad_dtb_o   (sad_dtb_o),
        .sad_busy_i  (sad_busy_i),
        .sad_dt_i    (sad_dt_i),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_ready_i (res_ready_i)
`ifdef SAD_FEEDER_CHECK_EN
        ,
        .mismatch_o  (mismatch_o)
`endif
    );

    function automatic logic [31:0] absd(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? 32'(a - b) : 32'(b - a);
    endfunction

    // Behavioural sad: sums pairs while enb is high, stays busy two more cycles, then publishes.
    always @(negedge clk) begin
        if (rst_i) begin
            resp_busy = 1'b0;
            resp_sum  = '0;
            tail      = 0;
            prev_enb  = 1'b0;
        end else begin
            if (sad_enb_o) begin
                if (!prev_enb) resp_sum = '0;
                resp_sum  = resp_sum + absd(sad_dta_o, sad_dtb_o);
                resp_busy = 1'b1;
                tail      = 2;
            end else if (resp_busy) begin
                if (tail > 0) begin
                    tail--;
                end else begin
                    resp_busy = 1'b0;
                    resp_dt   = resp_sum + 32'(corrupt);
                end
            end
            prev_enb = sad_enb_o;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Leaves the final B write pending so it shares a cycle with the caller's start.
    task automatic load_buffers(input bit a_ramp, input logic [7:0] a_val, input logic [7:0] b_val);
        for (int i = 0; i < N; i++) begin
            mA[i] = a_ramp ? 8'(i) : a_val;
            mB[i] = b_val;
        end
        for (int i = 0; i < N; i++) begin
            wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 8'(i); wr_data_i = mA[i];
            @(negedge clk);
        end
        for (int i = 0; i < N - 1; i++) begin
            wr_en_i = 1'b1; wr_sel_i = 1'b1; wr_addr_i = 8'(i); wr_data_i = mB[i];
            @(negedge clk);
        end
        wr_en_i = 1'b1; wr_sel_i = 1'b1; wr_addr_i = 8'(N - 1); wr_data_i = mB[N - 1];
    endtask

    task automatic run_stream(input string nm, input int busy_hold, input int ready_delay, input int exp);
        int tt, first_enb, last_enb, valid_t, enb_cnt, pair_err, hold_err, idle1, exp_first;
        logic [31:0] held;
        exp_first = (busy_hold + 1 > 2) ? busy_hold + 1 : 2;
        first_enb = -1; last_enb = -1; valid_t = -1;
        enb_cnt = 0; pair_err = 0; hold_err = 0; idle1 = -1; tt = 0;
        if (busy_hold > 0) force_busy = 1'b1;
        start_i = 1'b1;
        while (valid_t < 0 && tt < 2000) begin
            @(negedge clk);
            tt++;
            start_i = 1'b0;
            wr_en_i = 1'b0;
            if (tt == 1) idle1 = int'(idle_o);
            if (sad_enb_o) begin
                if (first_enb < 0) first_enb = tt;
                last_enb = tt;
                if (enb_cnt < N && (sad_dta_o !== mA[enb_cnt] || sad_dtb_o !== mB[enb_cnt])) pair_err++;
                enb_cnt++;
            end
            if (res_valid_o) valid_t = tt;
            if (tt >= busy_hold) force_busy = 1'b0;
        end
        check({nm, "_arm_idle"}, idle1, 0);
        check({nm, "_first_enb"}, first_enb, exp_first);
        check({nm, "_enb_cnt"}, enb_cnt, N);
        check({nm, "_enb_contig"}, last_enb - first_enb + 1, N);
        check({nm, "_pairs"}, pair_err, 0);
        check({nm, "_valid_lat"}, valid_t, exp_first + N + 5);
        check({nm, "_res"}, int'(res_data_o), exp);
`ifdef SAD_FEEDER_CHECK_EN
        check({nm, "_mismatch"}, int'(mismatch_o), int'(corrupt));
`endif
        held = res_data_o;
        for (int k = 0; k < ready_delay; k++) begin
            start_i   = k[0];
            wr_en_i   = ~k[0];
            wr_sel_i  = 1'b0;
            wr_addr_i = '0;
            wr_data_i = ~mA[0];
            @(negedge clk);
            if (res_valid_o !== 1'b1 || res_data_o !== held || sad_enb_o !== 1'b0 || idle_o !== 1'b0)
                hold_err++;
        end
        start_i = 1'b0;
        wr_en_i = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check({nm, "_hold_stable"}, hold_err, 0);
        check({nm, "_idle_after"}, int'(idle_o), 1);
        check({nm, "_valid_drop"}, int'(res_valid_o), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h00, 8'h00, 32640};
        vecs[1] = '{1'b0, 8'hAB, 8'hAB, 0};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 65280};
        vecs[3] = '{1'b0, 8'h00, 8'hFF, 65280};
        vecs[4] = '{1'b1, 8'h00, 8'h80, 16384};

        repeat (3) @(negedge clk);
        check("rst_idle", int'(idle_o), 1);
        check("rst_enb", int'(sad_enb_o), 0);
        check("rst_dta", int'(sad_dta_o), 0);
        check("rst_dtb", int'(sad_dtb_o), 0);
        check("rst_valid", int'(res_valid_o), 0);
        check("rst_data", int'(res_data_o), 0);
        rst_i = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_buffers(vecs[v].a_ramp, vecs[v].a_val, vecs[v].b_val);
            run_stream($sformatf("vec%0d", v), 0, 1, vecs[v].exp);
        end

        // sad busy before start: parked in ARM, stream begins the cycle after busy falls
        run_stream("busy_arm", 10, 1, vecs[4].exp);

        // Long HOLD with start and writes pulsed, then rerun to show the buffers were untouched
        run_stream("hold_wait", 0, 20, vecs[4].exp);
        run_stream("hold_bufchk", 0, 1, vecs[4].exp);

        // Async reset in the middle of a stream
        load_buffers(1'b1, 8'h00, 8'h00);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wr_en_i = 1'b0;
        cnt = 0;
        t = 0;
        while (cnt < 101 && t < 1000) begin
            @(negedge clk);
            t++;
            if (sad_enb_o) cnt++;
        end
        check("rstmid_reach", cnt, 101);
        check("rstmid_pair", int'(sad_dta_o), 100);
        #1 rst_i = 1'b1;
        #1;
        check("rstmid_idle", int'(idle_o), 1);
        check("rstmid_enb", int'(sad_enb_o), 0);
        check("rstmid_dta", int'(sad_dta_o), 0);
        check("rstmid_dtb", int'(sad_dtb_o), 0);
        check("rstmid_valid", int'(res_valid_o), 0);
        check("rstmid_data", int'(res_data_o), 0);
        @(negedge clk);
        rst_i = 1'b0;
        load_buffers(1'b0, 8'h10, 8'h03);
        run_stream("post_rst", 0, 1, 3328);

`ifdef SAD_FEEDER_CHECK_EN
        corrupt = 1'b1;
        run_stream("chk_bad", 0, 1, 3329);
        corrupt = 1'b0;
        run_stream("chk_good", 0, 1, 3328);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
